// File: rtl/alu_exec_stage.sv
// Registered execute stage: evaluates one ALU op per transfer, holds results in an
// output register backed by a one-entry skid so in_ready only depends on flopped state.
module alu_exec_stage #(
  parameter int WIDTH = 32,
  parameter int RDW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [RDW-1:0]   in_rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [RDW-1:0]   out_rd,
  output logic [3:0]       out_flags,
  output logic             err
);

  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  // Handshake: a transfer happens on a rising edge where valid && ready are both high;
  // valid must hold with stable payload until that edge, ready never depends on valid.
  state_t state, state_nxt;
  logic   acc_in, acc_out;
  logic   ld_new, ld_skid, ld_fwd;

  logic [WIDTH-1:0] skid_result;
  logic [RDW-1:0]   skid_rd;
  logic [3:0]       skid_flags;

  logic [WIDTH-1:0] f_result;
  logic [3:0]       f_flags;
  logic             f_illegal;
  logic             f_c, f_v;
  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   add_w, sub_w, sll_w, srl_w, sra_w;

  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign acc_in    = in_valid & in_ready;
  assign acc_out   = out_valid & out_ready;

  // Shifts run one bit wider so the last bit shifted out lands in the spare bit.
  assign shamt = in_b[SHW-1:0];
  assign add_w = {1'b0, in_a} + {1'b0, in_b};
  assign sub_w = {1'b0, in_a} - {1'b0, in_b};
  assign sll_w = {1'b0, in_a} << shamt;
  assign srl_w = {in_a, 1'b0} >> shamt;
  assign sra_w = $signed({in_a, 1'b0}) >>> shamt;

  always_comb begin
    f_result  = '0;
    f_c       = 1'b0;
    f_v       = 1'b0;
    f_illegal = 1'b0;
    case (in_op)
      4'd0:  f_result = in_a & in_b;
      4'd1:  f_result = in_a | in_b;
      4'd2:  f_result = in_a ^ in_b;
      4'd3:  f_result = ~(in_a | in_b);
      4'd4: begin
        f_result = add_w[WIDTH-1:0];
        f_c      = add_w[WIDTH];
        f_v      = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (add_w[WIDTH-1] != in_a[WIDTH-1]);
      end
      4'd5: begin
        f_result = sub_w[WIDTH-1:0];
        f_c      = ~sub_w[WIDTH];
        f_v      = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (sub_w[WIDTH-1] != in_a[WIDTH-1]);
      end
      4'd6: begin
        f_result = sll_w[WIDTH-1:0];
        f_c      = sll_w[WIDTH];
      end
      4'd7: begin
        f_result = srl_w[WIDTH:1];
        f_c      = srl_w[0];
      end
      4'd8: begin
        f_result = sra_w[WIDTH:1];
        f_c      = sra_w[0];
      end
      4'd9:  f_result = {{(WIDTH-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
      4'd10: f_result = {{(WIDTH-1){1'b0}}, (in_a < in_b)};
      4'd11: f_result = in_b;
      default: f_illegal = 1'b1;
    endcase
    f_flags = {f_result[WIDTH-1], (f_result == '0), f_c, f_v};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ld_new    = 1'b0;
    ld_skid   = 1'b0;
    ld_fwd    = 1'b0;
    case (state)
      EMPTY: begin
        if (acc_in) begin
          state_nxt = ONE;
          ld_new    = 1'b1;
        end
      end
      ONE: begin
        if (acc_in && !acc_out) begin
          state_nxt = TWO;
          ld_skid   = 1'b1;
        end else if (!acc_in && acc_out) begin
          state_nxt = EMPTY;
        end else if (acc_in && acc_out) begin
          ld_new = 1'b1;
        end
      end
      TWO: begin
        if (acc_out) begin
          state_nxt = ONE;
          ld_fwd    = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_result  <= '0;
      out_rd      <= '0;
      out_flags   <= '0;
      skid_result <= '0;
      skid_rd     <= '0;
      skid_flags  <= '0;
      err         <= 1'b0;
    end else begin
      if (ld_new) begin
        out_result <= f_result;
        out_rd     <= in_rd;
        out_flags  <= f_flags;
      end else if (ld_fwd) begin
        out_result <= skid_result;
        out_rd     <= skid_rd;
        out_flags  <= skid_flags;
      end
      if (ld_skid) begin
        skid_result <= f_result;
        skid_rd     <= in_rd;
        skid_flags  <= f_flags;
      end
      if (acc_in && f_illegal) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: directed vectors, backpressure, throughput and reset
// scenarios, with a scoreboard fed at input transfers and drained at output transfers.
module tb_alu_exec_stage;
  localparam int WIDTH = 32;
  localparam int RDW   = 5;
  localparam int W     = RDW + 4 + WIDTH;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_op;
  logic [WIDTH-1:0] in_a, in_b;
  logic [RDW-1:0]   in_rd;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [RDW-1:0]   out_rd;
  logic [3:0]       out_flags;
  logic             err;

  int n_vec = 0;
  int n_bad = 0;
  int n_out = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] sb_exp;

  alu_exec_stage #(.WIDTH(WIDTH), .RDW(RDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rd(out_rd), .out_flags(out_flags), .err(err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  // ---------------- reference model: {N,Z,C,V, result} ----------------
  function automatic logic [35:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0] r;
    logic        c, v;
    logic [32:0] wide;
    longint      s;
    int          sh;
    r = 32'd0; c = 1'b0; v = 1'b0;
    sh = int'(b[4:0]);
    case (op)
      4'd0: r = a & b;
      4'd1: r = a | b;
      4'd2: r = a ^ b;
      4'd3: r = ~(a | b);
      4'd4: begin
        wide = {1'b0, a} + {1'b0, b};
        r = wide[31:0]; c = wide[32];
        s = longint'($signed(a)) + longint'($signed(b));
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd5: begin
        r = a - b; c = (a >= b);
        s = longint'($signed(a)) - longint'($signed(b));
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd6: begin
        r = a;
        for (int i = 0; i < sh; i++) begin c = r[31]; r = {r[30:0], 1'b0}; end
      end
      4'd7: begin
        r = a;
        for (int i = 0; i < sh; i++) begin c = r[0]; r = {1'b0, r[31:1]}; end
      end
      4'd8: begin
        r = a;
        for (int i = 0; i < sh; i++) begin c = r[0]; r = {r[31], r[31:1]}; end
      end
      4'd9:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd10: r = (a < b) ? 32'd1 : 32'd0;
      4'd11: r = b;
      default: r = 32'd0;
    endcase
    return {r[31], (r == 32'd0), c, v, r};
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        n_out++;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL sb_unexpected got=%h (nothing expected)", {out_rd, out_flags, out_result});
        end else begin
          sb_exp = exp_q.pop_front();
          if ({out_rd, out_flags, out_result} !== sb_exp) begin
            n_bad++;
            $display("FAIL sb_data got=%h exp=%h", {out_rd, out_flags, out_result}, sb_exp);
          end
        end
      end
      if (in_valid && in_ready) exp_q.push_back({in_rd, model(in_op, in_a, in_b)});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd);
    logic acc;
    bit   done;
    done = 0;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_rd = rd;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) done = 1;
    end
    in_valid = 1'b0;
    if (!done) begin
      n_vec++; n_bad++;
      $display("FAIL send_timeout op=%0d never accepted", op);
    end
  endtask

  task automatic wait_drain();
    bit done;
    done = 0;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) done = 1;
    end
    n_vec++;
    if (!done) begin
      n_bad++;
      $display("FAIL drain_timeout pending=%0d", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; in_a = '0; in_b = '0; in_rd = '0;
    #12;
    n_vec++;
    if ({out_valid, in_ready, err} !== 3'b010) begin
      n_bad++; $display("FAIL reset_ctrl got=%b exp=010", {out_valid, in_ready, err});
    end
    n_vec++;
    if ({out_rd, out_flags, out_result} !== '0) begin
      n_bad++; $display("FAIL reset_data got=%h exp=0", {out_rd, out_flags, out_result});
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_vectors();
    logic [3:0]  t_op [15];
    logic [31:0] t_a  [15];
    logic [31:0] t_b  [15];
    logic [35:0] t_e  [15];
    t_op[0]  = 4'd1;  t_a[0]  = 32'h0;        t_b[0]  = 32'hFFFFFFFF; t_e[0]  = {4'b1000, 32'hFFFFFFFF};
    t_op[1]  = 4'd4;  t_a[1]  = 32'hFFFFFFFF; t_b[1]  = 32'h1;        t_e[1]  = {4'b0110, 32'h0};
    t_op[2]  = 4'd5;  t_a[2]  = 32'h80000000; t_b[2]  = 32'h1;        t_e[2]  = {4'b0011, 32'h7FFFFFFF};
    t_op[3]  = 4'd5;  t_a[3]  = 32'h1;        t_b[3]  = 32'h2;        t_e[3]  = {4'b1000, 32'hFFFFFFFF};
    t_op[4]  = 4'd8;  t_a[4]  = 32'h80000000; t_b[4]  = 32'd31;       t_e[4]  = {4'b1000, 32'hFFFFFFFF};
    t_op[5]  = 4'd6;  t_a[5]  = 32'h80000001; t_b[5]  = 32'd1;        t_e[5]  = {4'b0010, 32'h2};
    t_op[6]  = 4'd9;  t_a[6]  = 32'hFFFFFFFF; t_b[6]  = 32'h1;        t_e[6]  = {4'b0000, 32'h1};
    t_op[7]  = 4'd10; t_a[7]  = 32'hFFFFFFFF; t_b[7]  = 32'h1;        t_e[7]  = {4'b0100, 32'h0};
    t_op[8]  = 4'd3;  t_a[8]  = 32'h0;        t_b[8]  = 32'h0;        t_e[8]  = {4'b1000, 32'hFFFFFFFF};
    t_op[9]  = 4'd2;  t_a[9]  = 32'hAAAAAAAA; t_b[9]  = 32'hAAAAAAAA; t_e[9]  = {4'b0100, 32'h0};
    t_op[10] = 4'd4;  t_a[10] = 32'h7FFFFFFF; t_b[10] = 32'h1;        t_e[10] = {4'b1001, 32'h80000000};
    t_op[11] = 4'd7;  t_a[11] = 32'h3;        t_b[11] = 32'h21;       t_e[11] = {4'b0010, 32'h1};
    t_op[12] = 4'd6;  t_a[12] = 32'h80000000; t_b[12] = 32'h0;        t_e[12] = {4'b1000, 32'h80000000};
    t_op[13] = 4'd11; t_a[13] = 32'h0;        t_b[13] = 32'h5;        t_e[13] = {4'b0000, 32'h5};
    t_op[14] = 4'd0;  t_a[14] = 32'h0000F0F0; t_b[14] = 32'h0000FF00; t_e[14] = {4'b0000, 32'h0000F000};
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      send(t_op[i], t_a[i], t_b[i], 5'(i + 1));
      n_vec++;
      if ({out_valid, out_rd, out_flags, out_result} !== {1'b1, 5'(i + 1), t_e[i]}) begin
        n_bad++;
        $display("FAIL vec%0d op=%0d got v=%b rd=%0d f=%b r=%h exp rd=%0d f=%b r=%h", i, t_op[i],
                 out_valid, out_rd, out_flags, out_result, i + 1, t_e[i][35:32], t_e[i][31:0]);
      end
    end
    wait_drain();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send(4'd1, 32'd1, 32'd0, 5'd20);
    n_vec++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready1 got=%b exp=1", in_ready); end
    send(4'd1, 32'd2, 32'd0, 5'd21);
    n_vec++;
    if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready2 got=%b exp=0", in_ready); end
    in_valid = 1'b1; in_op = 4'd1; in_a = 32'd4; in_b = 32'd0; in_rd = 5'd22;
    repeat (3) begin
      @(posedge clk); #1;
      n_vec++;
      if ({in_ready, out_valid, out_result} !== {1'b0, 1'b1, 32'd1}) begin
        n_bad++;
        $display("FAIL bp_stall got rdy=%b v=%b r=%h exp rdy=0 v=1 r=1", in_ready, out_valid, out_result);
      end
    end
    out_ready = 1'b1;
    in_valid = 1'b0;
    send(4'd1, 32'd4, 32'd0, 5'd22);
    wait_drain();
  endtask

  task automatic test_throughput();
    int base;
    out_ready = 1'b1;
    base = n_out;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      in_op = 4'($urandom_range(0, 11));
      in_a  = ($urandom_range(0, 4) == 0) ? 32'h80000000 : $urandom;
      in_b  = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      in_rd = 5'($urandom_range(0, 31));
      @(negedge clk);
      n_vec++;
      if (in_ready !== 1'b1) begin n_bad++; $display("FAIL tp_ready%0d got=%b exp=1", i, in_ready); end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk); #1;
    n_vec++;
    if (n_out - base !== 100) begin
      n_bad++; $display("FAIL tp_count got=%0d exp=100", n_out - base);
    end
    n_vec++;
    if (err !== 1'b0) begin n_bad++; $display("FAIL tp_err got=%b exp=0", err); end
    wait_drain();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    send(4'd4, 32'd10, 32'd20, 5'd1);
    send(4'd4, 32'd30, 32'd40, 5'd2);
    #1; rst_n = 1'b0;
    #1;
    n_vec++;
    if ({out_valid, in_ready, out_result} !== {1'b0, 1'b1, 32'd0}) begin
      n_bad++;
      $display("FAIL rst_mid got v=%b rdy=%b r=%h exp v=0 rdy=1 r=0", out_valid, in_ready, out_result);
    end
    exp_q.delete();
    #1; rst_n = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_empty got=%b exp=0", out_valid); end
    out_ready = 1'b1;
    send(4'hF, $urandom, $urandom, 5'd9);
    n_vec++;
    if ({out_valid, out_rd, out_flags, out_result, err} !== {1'b1, 5'd9, 4'b0100, 32'd0, 1'b1}) begin
      n_bad++;
      $display("FAIL illegal got v=%b rd=%0d f=%b r=%h err=%b exp v=1 rd=9 f=0100 r=0 err=1",
               out_valid, out_rd, out_flags, out_result, err);
    end
    send(4'd4, 32'd2, 32'd3, 5'd10);
    n_vec++;
    if ({out_result, err} !== {32'd5, 1'b1}) begin
      n_bad++; $display("FAIL err_sticky got r=%h err=%b exp r=5 err=1", out_result, err);
    end
    wait_drain();
    #1; rst_n = 1'b0;
    #1;
    n_vec++;
    if (err !== 1'b0) begin n_bad++; $display("FAIL err_clear got=%b exp=0", err); end
    #1; rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_throughput();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
